// File: rtl/ram_pkg.sv
// Shared constants and helpers for the RAM arbiter slice.
package ram_pkg;

  localparam int unsigned DEF_ADDR_W = 29;
  localparam int unsigned DEF_DATA_W = 32;

  // Port-index width; a single-port arbiter still carries a 1-bit index.
  function automatic int unsigned port_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_tag_fifo.sv
// Synchronous FIFO of requester indices, one entry per outstanding read.
module ram_tag_fifo
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop_data = mem_q[rd_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter of NUM_PORTS requesters onto one RAM controller,
// steering in-order read returns back to the issuing port via a tag FIFO.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          port_valid,
  input  logic [NUM_PORTS-1:0]          port_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
  output logic [NUM_PORTS-1:0]          port_ready,
  output logic [NUM_PORTS-1:0]          port_rvalid,
  output logic [DATA_W-1:0]             port_rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_read_req,
  output logic                          mem_write_req,
  input  logic                          mem_read_ready,
  input  logic                          mem_write_ready,
  input  logic                          mem_stall,
  input  logic                          mem_read_data_valid,
  input  logic [DATA_W-1:0]             mem_read_data,
  output logic                          err_orphan
);

  localparam int unsigned IDX_W = port_idx_w(NUM_PORTS);

  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_found;
  logic                 sel_write;
  logic                 accept;
  logic                 tag_full;
  logic                 tag_empty;
  logic                 tag_pop;
  logic [IDX_W-1:0]     tag_head;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 orphan_q, orphan_d;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    int unsigned p;
    p         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      p = (32'(last_grant_q) + k) % NUM_PORTS;
      if (!sel_found && port_valid[IDX_W'(p)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(p);
      end
    end
  end

  assign sel_write = port_write[sel_idx];
  assign mem_addr  = port_addr[32'(sel_idx) * ADDR_W +: ADDR_W];
  assign mem_wdata = port_wdata[32'(sel_idx) * DATA_W +: DATA_W];

  // A full tag FIFO blocks reads even if a return frees a slot this cycle.
  assign accept = !rst && sel_found && !mem_stall &&
                  (sel_write ? mem_write_ready : (mem_read_ready && !tag_full));

  assign mem_write_req = accept && sel_write;
  assign mem_read_req  = accept && !sel_write;
  assign port_ready    = accept ? (NUM_PORTS'(1) << sel_idx) : '0;

  assign tag_pop = mem_read_data_valid && !tag_empty;

  ram_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (IDX_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_read_req),
    .push_data (sel_idx),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    orphan_d     = orphan_q;
    if (accept) last_grant_d = sel_idx;
    if (tag_pop) begin
      rvalid_d = NUM_PORTS'(1) << tag_head;
      rdata_d  = mem_read_data;
    end
    if (mem_read_data_valid && tag_empty) orphan_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      rvalid_q     <= '0;
      rdata_q      <= '0;
      orphan_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      orphan_q     <= orphan_d;
    end
  end

  assign port_rvalid = rvalid_q;
  assign port_rdata  = rdata_q;
  assign err_orphan  = orphan_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ram_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned AW = 29;
  localparam int unsigned DW = 32;
  localparam int unsigned TD = 4;

  logic             clk;
  logic             rst;
  logic [NP-1:0]    port_valid;
  logic [NP-1:0]    port_write;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_wdata;
  logic [NP-1:0]    port_ready;
  logic [NP-1:0]    port_rvalid;
  logic [DW-1:0]    port_rdata;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_read_req;
  logic             mem_write_req;
  logic             mem_read_ready;
  logic             mem_write_ready;
  logic             mem_stall;
  logic             mem_read_data_valid;
  logic [DW-1:0]    mem_read_data;
  logic             err_orphan;

  ram_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TAG_DEPTH (TD)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .port_valid          (port_valid),
    .port_write          (port_write),
    .port_addr           (port_addr),
    .port_wdata          (port_wdata),
    .port_ready          (port_ready),
    .port_rvalid         (port_rvalid),
    .port_rdata          (port_rdata),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_read_req        (mem_read_req),
    .mem_write_req       (mem_write_req),
    .mem_read_ready      (mem_read_ready),
    .mem_write_ready     (mem_write_ready),
    .mem_stall           (mem_stall),
    .mem_read_data_valid (mem_read_data_valid),
    .mem_read_data       (mem_read_data),
    .err_orphan          (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;

  // Reference model state
  int            lg;
  int            tagq[$];
  logic [NP-1:0] e_rvalid;
  logic [DW-1:0] e_rdata;
  logic          e_orphan;
  bit            g_acc;
  int            g_sel;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic step();
    bit            found;
    bit            acc;
    bit            wr;
    int            sel;
    logic [NP-1:0] e_ready;
    @(negedge clk);
    found = 0;
    sel   = 0;
    for (int k = 1; k <= NP; k++) begin
      if (!found && port_valid[(lg + k) % NP]) begin
        found = 1;
        sel   = (lg + k) % NP;
      end
    end
    wr  = port_write[sel];
    acc = found && !rst && !mem_stall &&
          (wr ? mem_write_ready : (mem_read_ready && tagq.size() < TD));
    e_ready = acc ? (NP'(1) << sel) : '0;

    chk("ready", 64'(port_ready), 64'(e_ready));
    chk("wreq", 64'(mem_write_req), 64'(acc && wr));
    chk("rreq", 64'(mem_read_req), 64'(acc && !wr));
    if (acc) chk("addr", 64'(mem_addr), 64'(port_addr[sel*AW +: AW]));
    if (acc && wr) chk("wdata", 64'(mem_wdata), 64'(port_wdata[sel*DW +: DW]));
    chk("rvalid", 64'(port_rvalid), 64'(e_rvalid));
    if (e_rvalid != '0) chk("rdata", 64'(port_rdata), 64'(e_rdata));
    chk("orphan", 64'(err_orphan), 64'(e_orphan));

    if (rst) begin
      tagq.delete();
      lg       = NP - 1;
      e_rvalid = '0;
      e_rdata  = '0;
      e_orphan = 1'b0;
    end else begin
      e_rvalid = '0;
      if (mem_read_data_valid) begin
        if (tagq.size() > 0) begin
          e_rvalid = NP'(1) << tagq[0];
          e_rdata  = mem_read_data;
          void'(tagq.pop_front());
        end else begin
          e_orphan = 1'b1;
        end
      end
      if (acc) begin
        lg = sel;
        if (!wr) tagq.push_back(sel);
      end
    end
    g_acc = acc;
    g_sel = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    lg = NP - 1;
    e_rvalid = '0;
    e_rdata = '0;
    e_orphan = 1'b0;
    g_acc = 0;
    g_sel = 0;
    rst = 1'b1;
    port_valid = '1;
    port_write = '1;
    port_addr = '0;
    port_wdata = '0;
    mem_read_ready = 1'b1;
    mem_write_ready = 1'b1;
    mem_stall = 1'b0;
    mem_read_data_valid = 1'b0;
    mem_read_data = '0;

    // Reset: requests present but nothing granted
    step();
    step();
    chk("rst_rdata", 64'(port_rdata), 64'h0);
    chk("rst_rvalid", 64'(port_rvalid), 64'h0);
    rst = 1'b0;

    // Continuous writes from both ports alternate grants
    port_addr[0 +: AW] = AW'(32'h10);
    port_addr[AW +: AW] = AW'(32'h20);
    port_wdata = {32'hBBBB0001, 32'hBBBB0000};
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt_acc", 64'(g_acc), 64'h1);
      chk("alt_sel", 64'(g_sel), 64'(i % 2));
    end

    // Reads from port 1 then port 0 return in order
    port_valid = 2'b10;
    port_write = 2'b00;
    port_addr[AW +: AW] = AW'(32'h100);
    step();
    port_valid = 2'b01;
    port_addr[0 +: AW] = AW'(32'h200);
    step();
    port_valid = 2'b00;
    mem_read_data_valid = 1'b1;
    mem_read_data = 32'hAAAA0001;
    step();
    chk("rd1_v", 64'(port_rvalid), 64'h2);
    chk("rd1_d", 64'(port_rdata), 64'hAAAA0001);
    mem_read_data = 32'hAAAA0002;
    step();
    chk("rd2_v", 64'(port_rvalid), 64'h1);
    chk("rd2_d", 64'(port_rdata), 64'hAAAA0002);
    mem_read_data_valid = 1'b0;
    step();

    // Tag FIFO full: fifth read held, writes still pass
    port_valid = 2'b01;
    port_write = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_acc", 64'(g_acc), 64'h1);
    end
    step();
    chk("full_hold", 64'(g_acc), 64'h0);
    port_valid = 2'b11;
    port_write = 2'b10;
    step();
    chk("full_wr_acc", 64'(g_acc), 64'h1);
    chk("full_wr_sel", 64'(g_sel), 64'h1);
    port_valid = 2'b01;
    mem_read_data_valid = 1'b1;
    mem_read_data = 32'hCCCC0001;
    step();
    chk("full_pop_hold", 64'(g_acc), 64'h0);
    mem_read_data_valid = 1'b0;
    step();
    chk("after_pop_acc", 64'(g_acc), 64'h1);
    port_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      mem_read_data_valid = 1'b1;
      mem_read_data = DW'(32'hD0D00000 + 32'(i));
      step();
    end
    mem_read_data_valid = 1'b0;
    step();

    // Global stall: nothing granted, round-robin point preserved
    port_valid = 2'b11;
    port_write = 2'b11;
    mem_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_acc", 64'(g_acc), 64'h0);
    end
    mem_stall = 1'b0;
    step();
    chk("stall_resume", 64'(g_sel), 64'h1);
    port_valid = 2'b00;

    // Orphan return with nothing outstanding
    mem_read_data_valid = 1'b1;
    step();
    mem_read_data_valid = 1'b0;
    chk("orphan_set", 64'(err_orphan), 64'h1);
    chk("orphan_norv", 64'(port_rvalid), 64'h0);
    for (int i = 0; i < 3; i++) step();
    chk("orphan_sticky", 64'(err_orphan), 64'h1);

    // Reset with reads outstanding drops the tags
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("orphan_cleared", 64'(err_orphan), 64'h0);
    port_valid = 2'b01;
    port_write = 2'b00;
    step();
    step();
    port_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_read_data_valid = 1'b1;
    step();
    chk("drop1_rv", 64'(port_rvalid), 64'h0);
    step();
    mem_read_data_valid = 1'b0;
    chk("drop2_rv", 64'(port_rvalid), 64'h0);
    chk("drop_orphan", 64'(err_orphan), 64'h1);
    step();

    // Randomized traffic; requesters hold until accepted
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!port_valid[p] && ($urandom % 3 == 0)) begin
          port_valid[p] = 1'b1;
          port_write[p] = 1'($urandom);
          port_addr[p*AW +: AW] = AW'($urandom);
          port_wdata[p*DW +: DW] = DW'($urandom);
        end
      end
      mem_stall = ($urandom % 10 == 0);
      mem_read_ready = ($urandom % 5 != 0);
      mem_write_ready = ($urandom % 5 != 0);
      mem_read_data_valid = (tagq.size() > 0) ? 1'($urandom) : ($urandom % 60 == 0);
      mem_read_data = DW'($urandom);
      rst = ($urandom % 400 == 0);
      step();
      if (g_acc) port_valid[g_sel] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requester channels, range 1..8.
REQ-002 Parameter ADDR_W, default 29: byte address width on every port and on the memory side.
REQ-003 Parameter DATA_W, default 32: data width on every port and on the memory side.
REQ-004 Parameter TAG_DEPTH, default 4: maximum outstanding reads, power of two, range 2..16.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 port_valid  in  NUM_PORTS  request present, one bit per port.
REQ-008 port_write  in  NUM_PORTS  1 = write, 0 = read, one bit per port.
REQ-009 port_addr  in  NUM_PORTS*ADDR_W  packed per-port addresses.
REQ-010 port_wdata  in  NUM_PORTS*DATA_W  packed per-port write data.
REQ-011 port_ready  out  NUM_PORTS  request accepted this cycle.
REQ-012 port_rvalid  out  NUM_PORTS  read data valid for that port.
REQ-013 port_rdata  out  DATA_W  read data, shared by all ports, qualified by port_rvalid.
REQ-014 mem_addr, mem_wdata  out  ADDR_W, DATA_W  selected request towards the ram controller.
REQ-015 mem_read_req, mem_write_req  out  1 each  request strobes to the ram controller.
REQ-016 mem_read_ready, mem_write_ready, mem_stall  in  1 each  controller readiness; mem_stall is the controller's global stall.
REQ-017 mem_read_data_valid  in  1  and mem_read_data  in  DATA_W: read return from the controller, in request order.
REQ-018 err_orphan  out  1  sticky: read data returned with no outstanding tag.

Function
REQ-019 Accept condition: !mem_stall && (write ? mem_write_ready : mem_read_ready && !tag_full) for the selected port.
REQ-020 Arbitration is round-robin: the search starts at last_grant+1 modulo NUM_PORTS; the first port with port_valid set is selected.
REQ-021 The mem_* request outputs are combinational from the selected port; mem_read_req/mem_write_req are asserted only when the accept condition holds.
REQ-022 port_ready[i] is asserted only for the selected port, only in the accept cycle; at most one bit is high per cycle.
REQ-023 last_grant updates to the granted port on accept and holds otherwise.
REQ-024 An accepted read pushes the port index into a TAG_DEPTH-entry tag FIFO.
REQ-025 tag_full blocks read grants even when a pop occurs in the same cycle; writes remain grantable while the FIFO is full.
REQ-026 mem_read_data_valid pops the FIFO head; port_rvalid[head] and port_rdata are registered, appearing exactly one cycle later.
REQ-027 A simultaneous push and pop with the FIFO non-full and non-empty leaves the count unchanged; pointers wrap modulo TAG_DEPTH.
REQ-028 mem_read_data_valid with an empty FIFO sets err_orphan, discards the data and leaves port_rvalid low.
REQ-029 A non-selected or blocked port sees port_ready low and must hold its request stable until accepted.

Reset
REQ-030 While rst is high: port_ready=0, port_rvalid=0, port_rdata=0, mem_read_req=0, mem_write_req=0, err_orphan=0, tag FIFO empty, last_grant=NUM_PORTS-1 (port 0 wins first).
REQ-031 Reset during outstanding reads drops all tags; any later return is handled per REQ-028.

Structure
REQ-032 Shared package ram_pkg holds the port-index width function (clog2 of NUM_PORTS) and the default ADDR_W/DATA_W constants.
REQ-033 One sub-module, ram_tag_fifo: a synchronous FIFO of port indices providing full and empty flags.

Verification
REQ-034 Ports 0 and 1 both request writes continuously with all readies high -> grants alternate 0,1,0,1; mem_write_req is high every cycle.
REQ-035 Port 1 reads 0x100, then port 0 reads 0x200; the controller returns 0xAAAA0001, then 0xAAAA0002 -> port_rvalid[1] carries 0xAAAA0001 and port_rvalid[0] carries 0xAAAA0002, each one cycle after its mem_read_data_valid.
REQ-036 Five reads are issued with TAG_DEPTH=4 and no returns -> the fifth read is held; a write from the other port is still accepted; the fifth read is granted the cycle after the first pop.
REQ-037 mem_stall is held high for 10 cycles with both ports valid -> no port_ready and no mem_*_req during those cycles; arbitration resumes at the saved round-robin point.
REQ-038 mem_read_data_valid pulses with no reads outstanding -> err_orphan=1 and stays 1 until rst; no port_rvalid.
REQ-039 rst is pulsed with 2 reads outstanding, then 2 returns arrive -> err_orphan=1 and all port_rvalid stay 0.
